// File: rtl/branch_resolver_pkg.sv
// Shared types and defaults for the branch resolver and its comparator.
package branch_resolver_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned ROB_IDX_W_DEF = 5;
  localparam int unsigned CNT_W_DEF     = 32;

  // RV32I conditional-branch funct3 encodings; 010/011 are unused.
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  // Resolver control state.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SQUASH   = 2'd2
  } res_state_e;

endpackage

// File: rtl/branch_resolver_cmp.sv
// Pure combinational RV32I branch comparator: reports whether funct3 is a
// legal branch encoding and whether the branch is taken.
module branch_cmp
  import branch_resolver_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            legal_o,
  output logic            taken_o
);

  logic eq, slt, ult;

  assign eq  = (rs1_i == rs2_i);
  assign slt = ($signed(rs1_i) < $signed(rs2_i));
  assign ult = (rs1_i < rs2_i);

  // Select the comparison for the encoded condition.
  always_comb begin
    legal_o = 1'b1;
    taken_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = !eq;
      F3_BLT:  taken_o = slt;
      F3_BGE:  taken_o = !slt;
      F3_BLTU: taken_o = ult;
      F3_BGEU: taken_o = !ult;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: evaluates branch direction, feeds the
// predictor update, raises a held redirect on mispredict and discards
// wrong-path branches until the pipeline flush completes.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned ROB_IDX_W = ROB_IDX_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 br_valid,
  output logic                 br_ready,
  input  logic [2:0]           br_funct3,
  input  logic [XLEN-1:0]      br_rs1_v,
  input  logic [XLEN-1:0]      br_rs2_v,
  input  logic [XLEN-1:0]      br_pc,
  input  logic [XLEN-1:0]      br_imm,
  input  logic                 br_pred_taken,
  input  logic [XLEN-1:0]      br_pred_target,
  input  logic [ROB_IDX_W-1:0] br_rob_idx,
  output logic                 branch_we,
  output logic                 branch_taken,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [ROB_IDX_W-1:0] redirect_rob_idx,
  input  logic                 redirect_ready,
  input  logic                 flush_done,
  output logic [CNT_W-1:0]     br_count,
  output logic [CNT_W-1:0]     mispred_count
);

  res_state_e           state_q, state_d;
  logic                 we_q, we_d;
  logic                 taken_q, taken_d;
  logic                 rv_q, rv_d;
  logic [XLEN-1:0]      rpc_q, rpc_d;
  logic [ROB_IDX_W-1:0] ridx_q, ridx_d;
  logic [CNT_W-1:0]     brc_q, brc_d;
  logic [CNT_W-1:0]     misc_q, misc_d;

  logic            cmp_legal, cmp_taken;
  logic [XLEN-1:0] taken_tgt, fall_tgt;
  logic            accept, mispredict;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3_i (br_funct3),
    .rs1_i    (br_rs1_v),
    .rs2_i    (br_rs2_v),
    .legal_o  (cmp_legal),
    .taken_o  (cmp_taken)
  );

  assign taken_tgt  = br_pc + br_imm;
  assign fall_tgt   = br_pc + XLEN'(4);
  assign mispredict = (cmp_taken != br_pred_taken) ||
                      (cmp_taken && (br_pred_target != taken_tgt));
  assign br_ready   = (state_q != ST_REDIRECT);
  assign accept     = br_valid && br_ready;

  // Next-state, predictor update, redirect payload and saturating counters.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    taken_d = taken_q;
    rv_d    = rv_q;
    rpc_d   = rpc_q;
    ridx_d  = ridx_q;
    brc_d   = brc_q;
    misc_d  = misc_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && cmp_legal) begin
          we_d    = 1'b1;
          taken_d = cmp_taken;
          brc_d   = (brc_q == '1) ? brc_q : brc_q + CNT_W'(1);
          if (mispredict) begin
            misc_d  = (misc_q == '1) ? misc_q : misc_q + CNT_W'(1);
            rv_d    = 1'b1;
            rpc_d   = cmp_taken ? taken_tgt : fall_tgt;
            ridx_d  = br_rob_idx;
            state_d = ST_REDIRECT;
          end
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          rv_d    = 1'b0;
          state_d = ST_SQUASH;
        end
      end
      ST_SQUASH: begin
        if (flush_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any pending redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      taken_q <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      ridx_q  <= '0;
      brc_q   <= '0;
      misc_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      taken_q <= taken_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      ridx_q  <= ridx_d;
      brc_q   <= brc_d;
      misc_q  <= misc_d;
    end
  end

  assign branch_we        = we_q;
  assign branch_taken     = taken_q;
  assign redirect_valid   = rv_q;
  assign redirect_pc      = rpc_q;
  assign redirect_rob_idx = ridx_q;
  assign br_count         = brc_q;
  assign mispred_count    = misc_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed table, hand sequences for the
// redirect/squash corners, and randomized traffic against a reference model.
module tb_branch_resolver;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic            clk, rst_n;
  logic            br_valid, br_ready;
  logic [2:0]      br_funct3;
  logic [XLEN-1:0] br_rs1_v, br_rs2_v, br_pc, br_imm, br_pred_target;
  logic            br_pred_taken;
  logic [RW-1:0]   br_rob_idx;
  logic            branch_we, branch_taken, redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [RW-1:0]   redirect_rob_idx;
  logic            redirect_ready, flush_done;
  logic [31:0]     br_count, mispred_count;

  // Narrow-counter instance used to observe saturation.
  logic            s_ready, s_we, s_taken, s_rv;
  logic [XLEN-1:0] s_rpc;
  logic [RW-1:0]   s_ridx;
  logic [1:0]      s_brc, s_misc;

  branch_resolver #(.XLEN(XLEN), .ROB_IDX_W(RW), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_funct3(br_funct3), .br_rs1_v(br_rs1_v), .br_rs2_v(br_rs2_v),
    .br_pc(br_pc), .br_imm(br_imm), .br_pred_taken(br_pred_taken),
    .br_pred_target(br_pred_target), .br_rob_idx(br_rob_idx),
    .branch_we(branch_we), .branch_taken(branch_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_rob_idx(redirect_rob_idx), .redirect_ready(redirect_ready),
    .flush_done(flush_done), .br_count(br_count), .mispred_count(mispred_count)
  );

  branch_resolver #(.XLEN(XLEN), .ROB_IDX_W(RW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(s_ready),
    .br_funct3(br_funct3), .br_rs1_v(br_rs1_v), .br_rs2_v(br_rs2_v),
    .br_pc(br_pc), .br_imm(br_imm), .br_pred_taken(br_pred_taken),
    .br_pred_target(br_pred_target), .br_rob_idx(br_rob_idx),
    .branch_we(s_we), .branch_taken(s_taken),
    .redirect_valid(s_rv), .redirect_pc(s_rpc),
    .redirect_rob_idx(s_ridx), .redirect_ready(redirect_ready),
    .flush_done(flush_done), .br_count(s_brc), .mispred_count(s_misc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            v;
    logic [2:0]      f3;
    logic [XLEN-1:0] rs1, rs2, pc, imm;
    logic            pt;
    logic [XLEN-1:0] ptgt;
    logic [RW-1:0]   idx;
  } br_in_t;

  typedef struct {
    br_in_t          b;
    logic            exp_legal, exp_taken, exp_mis;
    logic [XLEN-1:0] exp_rpc;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state: a pending redirect, a squash window, and plain counts.
  bit              m_redir, m_squash, m_we, m_taken;
  logic [XLEN-1:0] m_rpc;
  logic [RW-1:0]   m_ridx;
  int unsigned     n_br, n_mis;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned n, input int unsigned maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  function automatic void ref_dir(input logic [2:0] f, input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b, output bit legal, output bit t);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    legal = 1'b1;
    t     = 1'b0;
    case (f)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd4: t = (sa < sb);
      3'd5: t = (sa >= sb);
      3'd6: t = ({32'd0, a} < {32'd0, b});
      3'd7: t = ({32'd0, a} >= {32'd0, b});
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic br_in_t idle_in();
    br_in_t b;
    b = '{v: 1'b0, f3: 3'd0, rs1: '0, rs2: '0, pc: '0, imm: '0, pt: 1'b0, ptgt: '0, idx: '0};
    return b;
  endfunction

  function automatic br_in_t mk(input logic [2:0] f3, input logic [XLEN-1:0] rs1,
                                input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] pc,
                                input logic [XLEN-1:0] imm, input logic pt,
                                input logic [XLEN-1:0] ptgt, input logic [RW-1:0] idx);
    br_in_t b;
    b = '{v: 1'b1, f3: f3, rs1: rs1, rs2: rs2, pc: pc, imm: imm, pt: pt, ptgt: ptgt, idx: idx};
    return b;
  endfunction

  task automatic model_reset();
    m_redir = 0; m_squash = 0; m_we = 0; m_taken = 0;
    m_rpc = '0; m_ridx = '0; n_br = 0; n_mis = 0;
  endtask

  task automatic compare_all();
    chk("branch_we", branch_we, m_we);
    chk("branch_taken", branch_taken, m_taken);
    chk("redirect_valid", redirect_valid, m_redir);
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("redirect_rob_idx", redirect_rob_idx, m_ridx);
    chk("br_count", br_count, n_br);
    chk("mispred_count", mispred_count, n_mis);
    chk("br_count_sat", s_brc, sat(n_br, 3));
    chk("mispred_count_sat", s_misc, sat(n_mis, 3));
  endtask

  // One clock: drive inputs after the edge, advance the model at the edge,
  // compare one time unit later.
  task automatic cycle(input br_in_t b, input logic rr, input logic fd);
    bit legal, t, mis;
    logic [XLEN-1:0] tgt;
    br_valid = b.v; br_funct3 = b.f3; br_rs1_v = b.rs1; br_rs2_v = b.rs2;
    br_pc = b.pc; br_imm = b.imm; br_pred_taken = b.pt; br_pred_target = b.ptgt;
    br_rob_idx = b.idx; redirect_ready = rr; flush_done = fd;
    #1;
    chk("br_ready", br_ready, !m_redir);
    @(posedge clk);
    m_we = 0;
    if (m_redir) begin
      if (rr) begin m_redir = 0; m_squash = 1; end
    end else if (m_squash) begin
      if (fd) m_squash = 0;
    end else if (b.v) begin
      ref_dir(b.f3, b.rs1, b.rs2, legal, t);
      if (legal) begin
        tgt  = b.pc + b.imm;
        mis  = (t != b.pt) || (t && (b.ptgt != tgt));
        m_we = 1; m_taken = t; n_br++;
        if (mis) begin
          n_mis++; m_redir = 1; m_ridx = b.idx;
          m_rpc = t ? tgt : b.pc + 32'd4;
        end
      end
    end
    #1;
    compare_all();
  endtask

  vec_t tbl[9];
  br_in_t rb;
  int unsigned base_br, base_mis;

  initial begin
    tbl[0] = '{mk(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1, 32'h120, 5'd1), 1, 1, 0, 32'h0};
    tbl[1] = '{mk(3'b001, 32'd7, 32'd7, 32'h200, 32'h40, 1, 32'h240, 5'd9), 1, 0, 1, 32'h204};
    tbl[2] = '{mk(3'b100, 32'hFFFFFFFF, 32'd1, 32'h300, 32'h40, 1, 32'h340, 5'd2), 1, 1, 0, 32'h0};
    tbl[3] = '{mk(3'b110, 32'hFFFFFFFF, 32'd1, 32'h400, 32'h10, 0, 32'h0, 5'd3), 1, 0, 0, 32'h0};
    tbl[4] = '{mk(3'b000, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h8, 1, 32'h4, 5'd4), 1, 0, 1, 32'h0};
    tbl[5] = '{mk(3'b000, 32'd3, 32'd3, 32'h300, 32'h40, 1, 32'h300, 5'd17), 1, 1, 1, 32'h340};
    tbl[6] = '{mk(3'b010, 32'd3, 32'd3, 32'h600, 32'h40, 0, 32'h0, 5'd6), 0, 0, 0, 32'h0};
    tbl[7] = '{mk(3'b101, 32'h80000000, 32'd0, 32'h700, 32'h8, 0, 32'h0, 5'd7), 1, 0, 0, 32'h0};
    tbl[8] = '{mk(3'b111, 32'h80000000, 32'd0, 32'h500, 32'hFFFFFFF0, 0, 32'h0, 5'd31), 1, 1, 1, 32'h4F0};

    rst_n = 1'b0;
    model_reset();
    br_valid = 0; br_funct3 = '0; br_rs1_v = '0; br_rs2_v = '0; br_pc = '0; br_imm = '0;
    br_pred_taken = 0; br_pred_target = '0; br_rob_idx = '0; redirect_ready = 0; flush_done = 0;
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", br_ready, 1'b1);

    // Directed table: each branch from IDLE, recovering through REDIRECT/SQUASH.
    foreach (tbl[i]) begin
      base_br = n_br; base_mis = n_mis;
      cycle(tbl[i].b, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_we", i), branch_we, tbl[i].exp_legal);
      chk($sformatf("tbl%0d_rv", i), redirect_valid, tbl[i].exp_mis);
      chk($sformatf("tbl%0d_mis_inc", i), mispred_count - base_mis, tbl[i].exp_mis);
      if (tbl[i].exp_legal) chk($sformatf("tbl%0d_taken", i), branch_taken, tbl[i].exp_taken);
      if (tbl[i].exp_mis) begin
        chk($sformatf("tbl%0d_rpc", i), redirect_pc, tbl[i].exp_rpc);
        chk($sformatf("tbl%0d_ridx", i), redirect_rob_idx, tbl[i].b.idx);
        cycle(idle_in(), 1'b1, 1'b0);
        cycle(idle_in(), 1'b0, 1'b1);
      end
      cycle(idle_in(), 1'b0, 1'b0);
    end

    // Redirect held while ready is low, then squash, then recovery.
    cycle(tbl[1].b, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(tbl[0].b, 1'b0, 1'b0);
      chk("hold_rv", redirect_valid, 1'b1);
      chk("hold_rpc", redirect_pc, 32'h204);
      chk("hold_ready", br_ready, 1'b0);
    end
    cycle(idle_in(), 1'b1, 1'b0);
    chk("rv_cleared", redirect_valid, 1'b0);
    base_br = n_br;
    cycle(mk(3'b100, 32'd1, 32'd2, 32'h800, 32'h10, 0, 32'h0, 5'd8), 1'b0, 1'b0);
    cycle(mk(3'b100, 32'd1, 32'd2, 32'h804, 32'h10, 0, 32'h0, 5'd9), 1'b0, 1'b0);
    chk("squash_no_we", branch_we, 1'b0);
    cycle(mk(3'b100, 32'd1, 32'd2, 32'h808, 32'h10, 0, 32'h0, 5'd10), 1'b0, 1'b1);
    chk("squash_flush_same_cycle", br_count, base_br);
    cycle(tbl[0].b, 1'b0, 1'b0);
    chk("post_flush_we", branch_we, 1'b1);
    chk("post_flush_count", br_count, base_br + 1);

    // Ready already high when the redirect rises: one-cycle REDIRECT.
    cycle(tbl[5].b, 1'b1, 1'b0);
    cycle(idle_in(), 1'b1, 1'b0);
    chk("fast_handshake_rv", redirect_valid, 1'b0);
    chk("fast_handshake_ready", br_ready, 1'b1);
    cycle(idle_in(), 1'b0, 1'b1);

    // flush_done in IDLE is ignored; back-to-back accepts each update.
    cycle(idle_in(), 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(tbl[k == 1 ? 3 : 0].b, 1'b0, 1'b0);
      chk("b2b_we", branch_we, 1'b1);
    end

    // Reset while a redirect is pending.
    cycle(tbl[1].b, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("rst_ready", br_ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(idle_in(), 1'b0, 1'b0);
    chk("rst_count", br_count, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rb.v    = ($urandom_range(0, 3) != 0);
      rb.f3   = 3'($urandom_range(0, 7));
      rb.rs1  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom;
      rb.rs2  = ($urandom_range(0, 3) == 0) ? rb.rs1 :
                (($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom);
      rb.pc   = $urandom & 32'hFFFFFFFC;
      rb.imm  = 32'($signed(13'($urandom_range(0, 8191)) & 13'h1FFE));
      rb.pt   = $urandom_range(0, 1) != 0;
      rb.ptgt = ($urandom_range(0, 3) != 0) ? rb.pc + rb.imm : $urandom;
      rb.idx  = RW'($urandom_range(0, 31));
      cycle(rb, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Execute-stage consumer of conditional-branch predictions. It closes the loop back to the 2-bit saturating-counter predictor.
- Accepts one resolved branch per cycle from the branch functional unit and evaluates the actual direction.
- Drives the predictor update pair (branch_we/branch_taken).
- On a mispredict, raises a held redirect to fetch/ROB and squashes further branch results until the pipeline flush completes.

Parameters:
- XLEN, 32, data/PC width.
- ROB_IDX_W, 5, ROB tag width.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- br_valid  in  1  branch uop presented by execute.
- br_ready  out  1  resolver can accept; transfer occurs when br_valid && br_ready.
- br_funct3  in  3  RV32I branch funct3.
- br_rs1_v  in  XLEN  rs1 operand value.
- br_rs2_v  in  XLEN  rs2 operand value.
- br_pc  in  XLEN  branch PC.
- br_imm  in  XLEN  sign-extended B-immediate.
- br_pred_taken  in  1  direction predicted at decode.
- br_pred_target  in  XLEN  target fetch followed if predicted taken.
- br_rob_idx  in  ROB_IDX_W  ROB tag of branch.
- branch_we  out  1  predictor update strobe.
- branch_taken  out  1  actual direction for predictor update.
- redirect_valid  out  1  mispredict redirect request.
- redirect_pc  out  XLEN  correct next PC.
- redirect_rob_idx  out  ROB_IDX_W  tag of mispredicted branch; ROB squashes younger entries.
- redirect_ready  in  1  fetch/ROB accepts redirect.
- flush_done  in  1  one-cycle pulse: pipeline flush complete.
- br_count  out  CNT_W  resolved-and-counted branches.
- mispred_count  out  CNT_W  mispredicts.

Behaviour:
- Reset (rst_n low, async): state=IDLE. branch_we=0, branch_taken=0, redirect_valid=0, redirect_pc=0, redirect_rob_idx=0, both counters=0. br_ready=1 after reset deassertion.
- Direction compare on accept (combinational from inputs):
  - BEQ 000: rs1==rs2.
  - BNE 001: rs1!=rs2.
  - BLT 100: signed rs1<rs2.
  - BGE 101: signed rs1>=rs2.
  - BLTU 110: unsigned rs1<rs2.
  - BGEU 111: unsigned rs1>=rs2.
  - 010/011 are illegal: accepted and dropped. No update, no redirect, no count.
- Targets: taken_tgt = br_pc + br_imm; fallthrough = br_pc + 4. Both are XLEN-bit, wrap mod 2^XLEN.
- Mispredict = (actual != br_pred_taken) || (actual && br_pred_target != taken_tgt).
- Latency: everything below is registered and occurs one cycle after the accepting edge.
  - branch_we pulses exactly one cycle; branch_taken = actual.
  - br_count increments.
  - On mispredict, mispred_count also increments.
- Counters saturate at all-ones; no wrap.
- FSM, IDLE (br_ready=1):
  - Legal accept without mispredict: stay IDLE.
  - Mispredict: load redirect_pc (actual ? taken_tgt : fallthrough) and redirect_rob_idx, set redirect_valid, go to REDIRECT.
- FSM, REDIRECT (br_ready=0):
  - redirect_valid and its payload are held stable until redirect_ready.
  - On the cycle redirect_valid && redirect_ready: clear redirect_valid next cycle, go to SQUASH.
- FSM, SQUASH (br_ready=1):
  - Accepted branches are younger wrong-path work and are discarded: no branch_we, no counts, no redirect.
  - flush_done pulse: go to IDLE.
  - flush_done in the same cycle as a valid branch: that branch is still discarded.
- flush_done in IDLE or REDIRECT is ignored.
- redirect_ready already high when redirect_valid first rises: handshake completes that cycle, so REDIRECT lasts one cycle.
- Reset mid-REDIRECT/SQUASH: immediate return to reset values; the pending redirect is lost.
- Back-to-back accepts in IDLE: branch_we may stay high on consecutive cycles, one update per branch.

Decomposition:
- Shared package (params/rv32i_types):
  - branch funct3 enum (beq..bgeu).
  - resolver state enum (IDLE, REDIRECT, SQUASH).
  - CNT_W default.
- One natural sub-module: branch_cmp, a pure combinational funct3 comparator returning {legal, taken}. It is reusable by the ALU path.
- FSM, target adders and counters stay in the top level.

Test Plan:
- Predicted taken, BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred_target=0x120 -> next cycle branch_we=1, branch_taken=1, no redirect, br_count=1, mispred_count=0.
- Predicted taken, BNE rs1=rs2=7, pc=0x200 -> branch_taken=0, redirect_valid=1, redirect_pc=0x204, redirect_rob_idx echoed. redirect_ready held low 3 cycles -> payload stable, br_ready=0.
- In SQUASH, two BLT branches -> no branch_we, counts unchanged. flush_done pulse -> IDLE; next branch updates normally.
- Signed/unsigned: rs1=0xFFFFFFFF, rs2=1, BLT -> taken; BLTU -> not taken. Wrap: pc=0xFFFFFFFC, not taken, mispredicted -> redirect_pc=0x00000000.
- Taken correctly but pred_target wrong (0x300 vs 0x340) -> mispredict, redirect_pc=0x340, mispred_count+1. Illegal funct3 010 -> no update.
- rst_n asserted while in REDIRECT -> outputs clear asynchronously; after release, br_ready=1 and counters=0.
